vga_cfg_scheduler: RTL and testbench

Frame-synchronous configuration scheduler for the framebuffer-less VGA graphics core. Caravel-side writes land in a shadow register bank. On each end of visible frame (falling edge of `v_active`), any pending changes are committed to the active bank that drives the VGA core, one register per cycle. The block also accumulates per-frame collision bits and raises an interrupt, so register updates never tear mid-frame.

---
 rtl/vga_cfg_scheduler_if.sv | 38 +++
 rtl/vga_cfg_scheduler.sv | 167 ++++++++++++++++
 tb/tb_vga_cfg_scheduler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_cfg_scheduler_if.sv
// rtl/vga_cfg_scheduler_if.sv - configuration write bus between the host side and the VGA config scheduler
//
// Signals:
//   cfg_wr_i    single-cycle write strobe from the requester
//   cfg_addr_i  shadow register index
//   cfg_data_i  write data
//   cfg_ack_o   write accepted on this edge (combinational)
//   cfg_busy_o  scheduler is committing; requester must retry
// Modports: master = requester, slave = scheduler.

interface vga_cfg_scheduler_if #(
    parameter int NUM_REGS = 8,
    parameter int DW       = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic          cfg_wr_i;
    logic [AW-1:0] cfg_addr_i;
    logic [DW-1:0] cfg_data_i;
    logic          cfg_ack_o;
    logic          cfg_busy_o;

    modport master (
        output cfg_wr_i,
        output cfg_addr_i,
        output cfg_data_i,
        input  cfg_ack_o,
        input  cfg_busy_o
    );

    modport slave (
        input  cfg_wr_i,
        input  cfg_addr_i,
        input  cfg_data_i,
        output cfg_ack_o,
        output cfg_busy_o
    );
endinterface

// File: rtl/vga_cfg_scheduler.sv
// rtl/vga_cfg_scheduler.sv - frame-synchronous shadow-to-active configuration commit for the VGA core
//
// Host writes land in a shadow bank; at the falling edge of vga_v_active_i any
// pending changes are copied into the active bank, one register per cycle, so
// the VGA core never sees a register change mid-frame.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   cfg                     configuration write bus (vga_cfg_scheduler_if.slave)
//   vga_v_active_i/h_active active-video flags from the VGA core
//   collision_bits_i        per-pixel collision flags
//   active_regs_o           flattened active bank, reg k at [k*DW +: DW]
//   commit_o                one-cycle pulse when a commit completes
//   frame_cnt_o             count of frame ends (wraps)
//   collision_latched_o     collisions OR-accumulated over the previous frame
//   irq_o / irq_clr_i       collision interrupt level and its clear
//
// Build option: VGA_SCHED_COLLISION_EN builds the collision accumulator and
// interrupt; without it collision_latched_o and irq_o are tied to zero.

module vga_cfg_scheduler #(
    parameter int NUM_REGS = 8,
    parameter int DW       = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    vga_cfg_scheduler_if.slave     cfg,
    input  logic                   vga_v_active_i,
    input  logic                   vga_h_active_i,
    input  logic [11:0]            collision_bits_i,
    output logic [NUM_REGS*DW-1:0] active_regs_o,
    output logic                   commit_o,
    output logic [15:0]            frame_cnt_o,
    output logic [11:0]            collision_latched_o,
    output logic                   irq_o,
    input  logic                   irq_clr_i
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_REGS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] idx;
    logic          dirty;
    logic          v_active_q;
    logic          commit_q;
    logic [15:0]   frame_cnt_q;
    logic [DW-1:0] shadow [NUM_REGS];
    logic [DW-1:0] active [NUM_REGS];

    logic busy;
    logic ack;
    logic frame_end;

    assign busy      = (state == ST_COMMIT);
    assign ack       = cfg.cfg_wr_i & ~busy;
    assign frame_end = v_active_q & ~vga_v_active_i;

    assign cfg.cfg_busy_o = busy;
    assign cfg.cfg_ack_o  = ack;
    assign commit_o       = commit_q;
    assign frame_cnt_o    = frame_cnt_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign active_regs_o[k*DW +: DW] = active[k];
    end

    // Shadow bank: writes are never accepted while the commit walks the bank,
    // so the copy always sees a stable snapshot.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow[k] <= '0;
            end
        end else if (ack) begin
            shadow[cfg.cfg_addr_i] <= cfg.cfg_data_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            dirty       <= 1'b0;
            v_active_q  <= 1'b0;
            commit_q    <= 1'b0;
            frame_cnt_q <= 16'd0;
            for (int k = 0; k < NUM_REGS; k++) begin
                active[k] <= '0;
            end
        end else begin
            v_active_q <= vga_v_active_i;
            commit_q   <= 1'b0;
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (ack) begin
                dirty <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // A write accepted on the detect edge is already in the
                    // shadow before the first copy, so clearing dirty here
                    // loses nothing.
                    if (frame_end && dirty) begin
                        state <= ST_COMMIT;
                        idx   <= '0;
                        dirty <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    active[idx] <= shadow[idx];
                    idx         <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    commit_q <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VGA_SCHED_COLLISION_EN
    logic [11:0] acc;
    logic [11:0] latched_q;
    logic        irq_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc       <= 12'd0;
            latched_q <= 12'd0;
            irq_q     <= 1'b0;
        end else begin
            if (frame_end) begin
                latched_q <= acc;
                acc       <= 12'd0;
            end else if (vga_v_active_i && vga_h_active_i) begin
                acc <= acc | collision_bits_i;
            end
            // A new collision report outranks a simultaneous clear.
            if (frame_end && (acc != 12'd0)) begin
                irq_q <= 1'b1;
            end else if (irq_clr_i) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign collision_latched_o = latched_q;
    assign irq_o               = irq_q;
`else
    wire unused_collision = ^{collision_bits_i, vga_h_active_i, irq_clr_i};

    assign collision_latched_o = 12'd0;
    assign irq_o               = 1'b0;
`endif

endmodule

// File: tb/tb_vga_cfg_scheduler.sv
// tb/tb_vga_cfg_scheduler.sv - self-checking bench for vga_cfg_scheduler

module tb_vga_cfg_scheduler;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 3;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            vga_v_active_i;
    logic            vga_h_active_i;
    logic [11:0]     collision_bits_i;
    logic [N*DW-1:0] active_regs_o;
    logic            commit_o;
    logic [15:0]     frame_cnt_o;
    logic [11:0]     collision_latched_o;
    logic            irq_o;
    logic            irq_clr_i;

    vga_cfg_scheduler_if #(.NUM_REGS(N), .DW(DW)) cfg_if ();

    vga_cfg_scheduler #(.NUM_REGS(N), .DW(DW)) dut (
        .wb_clk_i            (wb_clk_i),
        .wb_rst_i            (wb_rst_i),
        .cfg                 (cfg_if),
        .vga_v_active_i      (vga_v_active_i),
        .vga_h_active_i      (vga_h_active_i),
        .collision_bits_i    (collision_bits_i),
        .active_regs_o       (active_regs_o),
        .commit_o            (commit_o),
        .frame_cnt_o         (frame_cnt_o),
        .collision_latched_o (collision_latched_o),
        .irq_o               (irq_o),
        .irq_clr_i           (irq_clr_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: commit timing is derived from the edge number of the
    // detect edge (d_m), not from any state machine.
    logic [DW-1:0] sh_m [N];
    logic [DW-1:0] ac_m [N];
    bit            dirty_m;
    bit            vq_m;
    int            d_m;
    int            cyc = 0;
    logic [15:0]   fc_m;
    logic [11:0]   acc_m;
    logic [11:0]   lat_m;
    bit            irq_m;

    function automatic bit in_commit(int e);
        return (e - d_m) >= 0 && (e - d_m) < N;
    endfunction

    function automatic bit in_seq(int e);
        return (e - d_m) >= 0 && (e - d_m) <= N;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            sh_m[k] = '0;
            ac_m[k] = '0;
        end
        dirty_m = 0;
        vq_m    = 0;
        d_m     = -1000;
        fc_m    = 16'd0;
        acc_m   = 12'd0;
        lat_m   = 12'd0;
        irq_m   = 0;
    endtask

    task automatic drive(input logic v, input logic h, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [11:0] cb, input logic clr);
        vga_v_active_i    = v;
        vga_h_active_i    = h;
        cfg_if.cfg_wr_i   = wr;
        cfg_if.cfg_addr_i = a;
        cfg_if.cfg_data_i = d;
        collision_bits_i  = cb;
        irq_clr_i         = clr;
    endtask

    task automatic check_outputs();
        logic [N*DW-1:0] flat;
        for (int k = 0; k < N; k++) flat[k*DW +: DW] = ac_m[k];
        chk("busy", cfg_if.cfg_busy_o, in_commit(cyc));
        chk("commit", commit_o, (cyc == d_m + N + 1));
        chk("active_regs", active_regs_o, flat);
        chk("frame_cnt", frame_cnt_o, fc_m);
        chk("coll_latched", collision_latched_o, lat_m);
        chk("irq", irq_o, irq_m);
    endtask

    task automatic tick();
        bit fe, ack, start;
        int e;
`ifdef VGA_SCHED_COLLISION_EN
        bit acc_nz;
`endif
        #1;
        e     = cyc;
        fe    = vq_m && !vga_v_active_i;
        ack   = cfg_if.cfg_wr_i && !in_commit(e);
        start = fe && dirty_m && !in_seq(e);
        chk("ack", cfg_if.cfg_ack_o, ack);
        @(posedge wb_clk_i);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (cyc == d_m + k + 1) ac_m[k] = sh_m[k];
        end
        if (ack) begin
            sh_m[cfg_if.cfg_addr_i] = cfg_if.cfg_data_i;
            dirty_m = 1;
        end
        if (start) begin
            d_m     = cyc;
            dirty_m = 0;
        end
        if (fe) fc_m++;
`ifdef VGA_SCHED_COLLISION_EN
        acc_nz = (acc_m != 12'd0);
        if (fe) begin
            lat_m = acc_m;
            acc_m = 12'd0;
        end else if (vga_v_active_i && vga_h_active_i) begin
            acc_m |= collision_bits_i;
        end
        if (fe && acc_nz) irq_m = 1;
        else if (irq_clr_i) irq_m = 0;
`endif
        vq_m = vga_v_active_i;
        #1;
        check_outputs();
    endtask

    initial begin
        logic [11:0] coll_exp;
        model_reset();
        wb_rst_i = 1'b1;
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (3) @(posedge wb_clk_i);
        #1;
        check_outputs();
        wb_rst_i = 1'b0;

        // Write reg 3 mid-frame; it must appear only after the frame end.
        drive(1, 1, 0, '0, '0, '0, 0);
        tick();
        drive(1, 1, 1, 3'd3, 16'h0F00, '0, 0);
        tick();
        drive(1, 1, 0, '0, '0, '0, 0);
        repeat (3) tick();
        chk("tp_reg3_pre", active_regs_o[3*DW +: DW], 16'h0000);
        drive(0, 0, 0, '0, '0, '0, 0);
        tick();
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j <= 4) chk("tp_reg3", active_regs_o[3*DW +: DW], (j == 4) ? 16'h0F00 : 16'h0000);
            if (j == 9) chk("tp_commit", commit_o, 1'b1);
        end

        // Frame end with no pending writes.
        drive(1, 0, 0, '0, '0, '0, 0);
        repeat (4) tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (12) tick();
        chk("tp_frame_cnt", frame_cnt_o, 16'd2);

        // Write on the detect cycle, then a refused write during COMMIT and its retry.
        drive(1, 0, 1, 3'd1, 16'hA5A5, '0, 0);
        tick();
        drive(1, 0, 0, '0, '0, '0, 0);
        tick();
        drive(0, 0, 1, 3'd5, 16'h5A5A, '0, 0);
        tick();
        drive(0, 0, 1, 3'd6, 16'hBEEF, '0, 0);
        tick();
        chk("tp_busy_ack", cfg_if.cfg_ack_o, 1'b0);
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (9) tick();
        chk("tp_reg5", active_regs_o[5*DW +: DW], 16'h5A5A);
        drive(0, 0, 1, 3'd6, 16'hBEEF, '0, 0);
        tick();
        drive(1, 0, 0, '0, '0, '0, 0);
        repeat (3) tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (11) tick();
        chk("tp_reg6", active_regs_o[6*DW +: DW], 16'hBEEF);

        // Collision accumulation, hold, and set-versus-clear priority.
`ifdef VGA_SCHED_COLLISION_EN
        coll_exp = 12'h332;
`else
        coll_exp = 12'h000;
`endif
        drive(1, 1, 0, '0, '0, 12'h302, 0);
        tick();
        drive(1, 1, 0, '0, '0, 12'h030, 0);
        tick();
        drive(1, 0, 0, '0, '0, 12'hFFF, 0);
        tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (2) tick();
        chk("tp_coll", collision_latched_o, coll_exp);
        drive(1, 1, 0, '0, '0, '0, 0);
        repeat (3) tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (2) tick();
        chk("tp_coll_zero", collision_latched_o, 12'h000);
        drive(1, 1, 0, '0, '0, 12'h001, 0);
        repeat (2) tick();
        drive(0, 0, 0, '0, '0, '0, 1);
        tick();
        chk("tp_set_wins", irq_o, coll_exp != 12'h000);
        tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        tick();

        // Reset asserted while the commit is at index 4.
        drive(1, 0, 1, 3'd7, 16'h1234, '0, 0);
        tick();
        drive(1, 0, 0, '0, '0, '0, 0);
        repeat (2) tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        tick();
        repeat (4) tick();
        #2;
        wb_rst_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        tick();
        drive(1, 0, 0, '0, '0, '0, 0);
        repeat (3) tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (12) tick();

        // Frame counter wrap from 0xFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        fc_m = 16'hFFFF;
        drive(1, 0, 0, '0, '0, '0, 0);
        repeat (2) tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        repeat (2) tick();
        chk("tp_wrap", frame_cnt_o, 16'h0000);

        // Randomized frames, including frame ends that land inside a commit.
        for (int f = 0; f < 60; f++) begin
            int la, lb;
            la = $urandom_range(2, 30);
            lb = $urandom_range(1, 14);
            for (int i = 0; i < la; i++) begin
                drive(1, 1'($urandom % 2), ($urandom % 4) == 0, AW'($urandom), DW'($urandom),
                      (($urandom % 3) == 0) ? 12'($urandom) : 12'h000, ($urandom % 16) == 0);
                tick();
            end
            for (int i = 0; i < lb; i++) begin
                drive(0, 1'($urandom % 2), ($urandom % 3) == 0, AW'($urandom), DW'($urandom),
                      12'($urandom), ($urandom % 8) == 0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
